app_go_button_ui: RTL
=====================

APP_GO_BUTTON_UI -- requirements
Module: app_go_button_ui

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable cycles needed to accept a button level (20 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_HALF_PERIOD, default 12500000, meaning the cycles per status LED toggle while RUN (250 ms).
REQ-003 SHALL have parameter GO_TIMEOUT_CYCLES, default 50000000, meaning the maximum cycles in GO awaiting acknowledge (used only when REQ-023 is enabled).
REQ-004 SHALL have port clock, input, 1 bit: the single clock, 50 MHz FPGA clock; all logic on posedge clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port button_n, input, 1 bit: raw asynchronous push button, active-low, bouncy.
REQ-007 SHALL have port application_active, input, 1 bit: level from the application shell, high while the application runs.
REQ-008 SHALL have port application_go, output, 1 bit: level request to the application shell.
REQ-009 SHALL have port status_led, output, 1 bit: UI activity LED.
REQ-010 SHALL have port ui_state, output, 2 bits: current FSM state encoding.
REQ-011 SHALL have port go_timeout, output, 1 bit: one-cycle pulse on GO timeout.

Function
REQ-012 SHALL pass button_n through a 2-flop synchronizer before any other use.
REQ-013 Debounce: counter increments each cycle the synchronized level differs from the accepted level; clears when they match; on reaching DEBOUNCE_CYCLES, updates the accepted level and clears.
REQ-014 Press event: one-cycle internal pulse when the accepted level goes released to pressed; release produces no event.
REQ-015 Latency: for a clean press, application_go SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples button_n low.
REQ-016 FSM states and encoding: IDLE=0, GO=1, RUN=2; value 3 unused and SHALL recover to IDLE the next cycle.
REQ-017 IDLE: on press event, go to GO. If application_active=1 in IDLE, go directly to RUN without asserting application_go; this takes priority over a simultaneous press.
REQ-018 GO: application_go=1 (registered, equal to state==GO); on application_active=1, go to RUN.
REQ-019 RUN: application_go=0; on application_active=0, go to IDLE.
REQ-020 Press events in GO or RUN SHALL be ignored and not queued.
REQ-021 status_led: 0 in IDLE; 1 in GO; in RUN, starts at 1 on entry, then toggles every BLINK_HALF_PERIOD cycles; the blink counter clears on every RUN entry.
REQ-022 Counter widths SHALL come from $clog2 of the parameter plus 1; no counter SHALL wrap. Each counter saturates or clears before overflow.

Configuration
REQ-023 Macro APP_UI_GO_TIMEOUT_EN: when defined, GO counts cycles; at GO_TIMEOUT_CYCLES without acknowledge, go to IDLE and pulse go_timeout for one cycle. When undefined, GO waits indefinitely, go_timeout is tied to 0, and no timeout counter is built.

Reset
REQ-024 While reset=1 on a clock edge: state=IDLE, application_go=0, status_led=0, go_timeout=0, ui_state=0, all counters=0, synchronizer flops=1, accepted level=released.
REQ-025 Reset asserted mid-GO or mid-RUN SHALL drop application_go the edge after reset is sampled. A button held through reset release SHALL NOT produce a press event until it has been released and pressed again.

Structure
REQ-026 Package app_ui_pkg SHALL hold the state enum typedef (ui_state_t) and the default constants for all three parameters.
REQ-027 Synchronizer plus debounce SHALL be a sub-module button_debouncer, parameterised by DEBOUNCE_CYCLES, with outputs for the accepted level and the press pulse.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=3, GO_TIMEOUT_CYCLES=8)
REQ-028 Clean press: button_n low at edge 0 -> application_go=1 after edge 7; application_active=1 two cycles later -> RUN, go=0, LED 1,1,1,0,0,0,1...
REQ-029 Bounce: button_n toggles every 2 cycles for 20 cycles, then settles low -> exactly one GO entry, go rises 7 edges after settling.
REQ-030 Timeout (macro defined): press, application_active held 0 -> go high 8 cycles, then IDLE with go_timeout one-cycle pulse. Macro undefined: go stays high for 100 cycles, go_timeout=0.
REQ-031 Priority and ignore: application_active=1 in the same cycle as a press event -> RUN directly, go never 1. A press during RUN -> no state change.
REQ-032 Reset mid-RUN with button held: reset one cycle -> all outputs 0 next edge. Reset released with button still held -> no GO. Release then press -> GO after 7 edges.

Source files
------------

// File: rtl/app_ui_pkg.sv
// Shared types and default constants for the GO-button user interface.
package app_ui_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGo   = 2'd1,
        StRun  = 2'd2,
        StBad  = 2'd3
    } ui_state_t;

    localparam int unsigned DebounceCyclesDefault  = 1000000;   // 20 ms at 50 MHz
    localparam int unsigned BlinkHalfPeriodDefault = 12500000;  // 250 ms at 50 MHz
    localparam int unsigned GoTimeoutCyclesDefault = 50000000;  // 1 s at 50 MHz

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer and debouncer for an active-low push button.
// Emits a single press pulse per accepted released->pressed transition.
module button_debouncer
    import app_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic level_n,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [1:0]      sync_q;
    logic            sync_lvl;
    logic            acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;
    logic            armed_q, armed_d;
    logic [1:0]      settle_q, settle_d;

    assign sync_lvl = sync_q[1];

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        press_d  = 1'b0;
        armed_d  = armed_q;
        settle_d = settle_q;
        if (settle_q != 2'd2) begin
            settle_d = settle_q + 2'd1;
        end
        if (sync_lvl == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            acc_d   = sync_lvl;
            cnt_d   = '0;
            press_d = armed_q && !sync_lvl;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Arm only once a genuine released sample has passed the reset-preloaded flops,
        // so a button held through reset cannot generate a press.
        if ((settle_q == 2'd2) && sync_lvl && acc_q) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= 2'b11;
            acc_q    <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            sync_q   <= {sync_q[0], button_n};
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
        end
    end

    assign level_n = acc_q;
    assign press   = press_q;

endmodule

// File: rtl/app_go_button_ui.sv
// GO-button UI: debounced press requests the application to start, LED shows activity.
// Optional GO acknowledge timeout is built when APP_UI_GO_TIMEOUT_EN is defined.
module app_go_button_ui
    import app_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DebounceCyclesDefault,
    parameter int unsigned BLINK_HALF_PERIOD = BlinkHalfPeriodDefault,
    parameter int unsigned GO_TIMEOUT_CYCLES = GoTimeoutCyclesDefault
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_n,
    input  logic       application_active,
    output logic       application_go,
    output logic       status_led,
    output logic [1:0] ui_state,
    output logic       go_timeout
);

    localparam int unsigned BlinkW = $clog2(BLINK_HALF_PERIOD) + 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_PERIOD - 1);

    logic              level_n;
    logic              press;
    ui_state_t         state_q, state_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              led_q, led_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock   (clock),
        .reset   (reset),
        .button_n(button_n),
        .level_n (level_n),
        .press   (press)
    );

`ifdef APP_UI_GO_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(GO_TIMEOUT_CYCLES) + 1;
    localparam logic [ToW-1:0] ToLast = ToW'(GO_TIMEOUT_CYCLES - 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           go_timeout_q, go_timeout_d;
`endif

    always_comb begin
        state_d = state_q;
`ifdef APP_UI_GO_TIMEOUT_EN
        go_timeout_d = 1'b0;
        to_cnt_d     = (state_q == StGo) ? to_cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            StIdle: begin
                // An already-running application wins over a simultaneous press.
                if (application_active) begin
                    state_d = StRun;
                end else if (press) begin
                    state_d = StGo;
                end
            end
            StGo: begin
                if (application_active) begin
                    state_d = StRun;
                end
`ifdef APP_UI_GO_TIMEOUT_EN
                else if (to_cnt_q == ToLast) begin
                    state_d      = StIdle;
                    go_timeout_d = 1'b1;
                    to_cnt_d     = '0;
                end
`endif
            end
            StRun: begin
                if (!application_active) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outside RUN the blink phase is held at its entry value so RUN always starts lit.
    always_comb begin
        blink_cnt_d = '0;
        led_d       = 1'b1;
        if (state_q == StRun) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                led_d       = !led_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                led_d       = led_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
        end
    end

`ifdef APP_UI_GO_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q     <= '0;
            go_timeout_q <= 1'b0;
        end else begin
            to_cnt_q     <= to_cnt_d;
            go_timeout_q <= go_timeout_d;
        end
    end

    assign go_timeout = go_timeout_q;
`else
    assign go_timeout = 1'b0;
`endif

    assign application_go = (state_q == StGo);
    assign status_led     = (state_q == StGo) || ((state_q == StRun) && led_q);
    assign ui_state       = state_q;

    logic unused_level;
    assign unused_level = level_n;

endmodule
